// File: rtl/vpu_alu_si_reduce_max_pkg.sv
// vpu_alu_si_reduce_max_pkg: shared types and constants for the signed max/min reduction
package vpu_alu_si_reduce_max_pkg;
  localparam int OPERAND_WIDTH = 32;
  typedef enum logic [1:0] {RED_IDLE, RED_ACCUM, RED_OUTPUT} red_state_t;
  typedef enum logic {RED_MAX, RED_MIN} red_op_t;
  localparam logic [OPERAND_WIDTH-1:0] SI_MIN_VAL = {1'b1, {(OPERAND_WIDTH-1){1'b0}}};
  localparam logic [OPERAND_WIDTH-1:0] SI_MAX_VAL = {1'b0, {(OPERAND_WIDTH-1){1'b1}}};
endpackage

// File: rtl/vpu_si_cmp_sel.sv
// vpu_si_cmp_sel: signed max/min select, ties keep a
module vpu_si_cmp_sel #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op_min,
  output logic [WIDTH-1:0] sel
);
  always_comb sel = op_min ? (($signed(b) < $signed(a)) ? b : a) : (($signed(b) > $signed(a)) ? b : a);
endmodule

// File: rtl/vpu_alu_si_reduce_max.sv
// vpu_alu_si_reduce_max: folds a stream of signed lane results into one max/min scalar
module vpu_alu_si_reduce_max #(
  parameter int OPERAND_WIDTH = vpu_alu_si_reduce_max_pkg::OPERAND_WIDTH,
  parameter int LEN_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic [LEN_WIDTH-1:0]     len_i,
  input  logic                     op_min_i,
  input  logic                     in_valid_i,
  input  logic [OPERAND_WIDTH-1:0] in_data_i,
  output logic                     in_ready_o,
  output logic                     out_valid_o,
  output logic [OPERAND_WIDTH-1:0] out_data_o,
  input  logic                     out_ready_i,
  output logic                     busy_o
);
  import vpu_alu_si_reduce_max_pkg::*;
  localparam logic [OPERAND_WIDTH-1:0] min_val = {1'b1, {(OPERAND_WIDTH-1){1'b0}}};
  localparam logic [OPERAND_WIDTH-1:0] max_val = {1'b0, {(OPERAND_WIDTH-1){1'b1}}};
  red_state_t state, state_next;
  red_op_t op;
  logic [LEN_WIDTH-1:0] len, cnt;
  logic [OPERAND_WIDTH-1:0] acc, sel;
  logic start_ok, accept, last;
  assign start_ok = start_i && state == RED_IDLE;
  assign accept = in_valid_i && state == RED_ACCUM;
  assign last = accept && cnt == len - 1'b1;
  vpu_si_cmp_sel #(.WIDTH(OPERAND_WIDTH)) u_sel (
    .a(acc),
    .b(in_data_i),
    .op_min(op == RED_MIN),
    .sel(sel)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RED_IDLE;
      op <= RED_MAX;
      len <= '0;
      cnt <= '0;
      acc <= '0;
    end else begin
      state <= state_next;
      if (start_ok) begin
        op <= red_op_t'(op_min_i);
        len <= len_i;
        cnt <= '0;
        acc <= op_min_i ? max_val : min_val;
      end else if (accept) begin
        cnt <= cnt + 1'b1;
        acc <= sel;
      end
    end
  end
  always_comb begin
    state_next = state;
    if (state == RED_IDLE) state_next = start_i ? (len_i == '0 ? RED_OUTPUT : RED_ACCUM) : RED_IDLE;
    else if (state == RED_ACCUM) state_next = last ? RED_OUTPUT : RED_ACCUM;
    else state_next = out_ready_i ? RED_IDLE : RED_OUTPUT;
  end
  always_comb begin
    in_ready_o = state == RED_ACCUM;
    out_valid_o = state == RED_OUTPUT;
    out_data_o = (state == RED_OUTPUT) ? acc : '0;
    busy_o = state != RED_IDLE;
  end
endmodule

// File: tb/tb_vpu_alu_si_reduce_max.sv
// tb_vpu_alu_si_reduce_max: directed vector bench for the signed max/min reduction
module tb_vpu_alu_si_reduce_max;
  typedef struct packed {
    logic             opm;
    logic [31:0]      n;
    logic [1:0]       gaps;
    logic [3:0][31:0] d;
    logic [31:0]      exp;
    logic [31:0]      lat;
  } vec_t;
  logic clk = 0;
  logic rst_n = 0;
  logic start_i = 0;
  logic [7:0] len_i = 0;
  logic op_min_i = 0;
  logic in_valid_i = 0;
  logic [31:0] in_data_i = 0;
  logic in_ready_o, out_valid_o, busy_o;
  logic [31:0] out_data_o;
  logic out_ready_i = 1;
  int n_vec = 0;
  int n_fail = 0;
  logic [31:0] data [256];
  logic [31:0] res;
  int lat;
  vec_t vt [8];
  always #5 clk = ~clk;
  vpu_alu_si_reduce_max dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_i(start_i),
    .len_i(len_i),
    .op_min_i(op_min_i),
    .in_valid_i(in_valid_i),
    .in_data_i(in_data_i),
    .in_ready_o(in_ready_o),
    .out_valid_o(out_valid_o),
    .out_data_o(out_data_o),
    .out_ready_i(out_ready_i),
    .busy_o(busy_o)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic run(input logic opm, input int n, input int gaps, output logic [31:0] r, output int l);
    int i = 0;
    logic beat;
    @(posedge clk) #1;
    start_i = 1;
    len_i = n[7:0];
    op_min_i = opm;
    @(posedge clk) #1;
    start_i = 0;
    l = 1;
    while (!out_valid_o && l < 2000) begin
      in_valid_i = (i < n) && (gaps == 0 || (gaps == 1 && (l % 2) == 1) || (gaps == 2 && $urandom_range(0, 2) != 0));
      in_data_i = data[i];
      beat = in_valid_i && in_ready_o;
      @(posedge clk) #1;
      if (beat) i++;
      l++;
    end
    in_valid_i = 0;
    chk("done", {31'd0, out_valid_o}, 32'd1);
    r = out_data_o;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready_o}, 0);
    chk("rst_out_valid", {31'd0, out_valid_o}, 0);
    chk("rst_out_data", out_data_o, 0);
    chk("rst_busy", {31'd0, busy_o}, 0);
    rst_n = 1;
    vt[0] = '{opm: 0, n: 4, gaps: 0, d: {32'd7, -32'sd128, 32'd7, -32'sd3}, exp: 32'd7, lat: 5};
    vt[1] = '{opm: 1, n: 3, gaps: 1, d: {32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF}, exp: 32'h8000_0000, lat: 6};
    vt[2] = '{opm: 0, n: 0, gaps: 0, d: '0, exp: 32'h8000_0000, lat: 1};
    vt[3] = '{opm: 1, n: 0, gaps: 0, d: '0, exp: 32'h7FFF_FFFF, lat: 1};
    vt[4] = '{opm: 0, n: 1, gaps: 0, d: {32'd0, 32'd0, 32'd0, 32'd5}, exp: 32'd5, lat: 2};
    vt[5] = '{opm: 1, n: 4, gaps: 0, d: {32'd3, -32'sd2, -32'sd2, 32'd10}, exp: 32'hFFFF_FFFE, lat: 5};
    vt[6] = '{opm: 0, n: 3, gaps: 0, d: {32'd0, -32'sd1, -32'sd9, -32'sd5}, exp: 32'hFFFF_FFFF, lat: 4};
    vt[7] = '{opm: 1, n: 2, gaps: 1, d: {32'd0, 32'd0, 32'd200, 32'd100}, exp: 32'd100, lat: 4};
    for (int v = 0; v < 8; v++) begin
      for (int k = 0; k < 4; k++) data[k] = vt[v].d[k];
      run(vt[v].opm, int'(vt[v].n), int'(vt[v].gaps), res, lat);
      chk($sformatf("vec%0d_data", v), res, vt[v].exp);
      chk($sformatf("vec%0d_lat", v), lat, vt[v].lat);
      chk($sformatf("vec%0d_in_ready", v), {31'd0, in_ready_o}, 0);
      chk($sformatf("vec%0d_busy", v), {31'd0, busy_o}, 1);
      @(posedge clk) #1;
      chk($sformatf("vec%0d_one_cycle", v), {31'd0, out_valid_o}, 0);
      chk($sformatf("vec%0d_idle", v), {31'd0, busy_o}, 0);
    end
    @(posedge clk) #1;
    start_i = 1;
    len_i = 4;
    op_min_i = 0;
    @(posedge clk) #1;
    start_i = 0;
    in_valid_i = 1;
    in_data_i = 1;
    @(posedge clk) #1;
    in_data_i = 2;
    @(posedge clk) #1;
    in_valid_i = 0;
    rst_n = 0;
    @(posedge clk) #1;
    chk("midrst_busy", {31'd0, busy_o}, 0);
    chk("midrst_out_valid", {31'd0, out_valid_o}, 0);
    chk("midrst_in_ready", {31'd0, in_ready_o}, 0);
    rst_n = 1;
    data[0] = 5;
    run(0, 1, 0, res, lat);
    chk("midrst_fresh", res, 5);
    @(posedge clk) #1;
    out_ready_i = 0;
    data[0] = 3;
    data[1] = 9;
    run(0, 2, 0, res, lat);
    for (int c = 0; c < 6; c++) begin
      start_i = (c == 2);
      len_i = 1;
      op_min_i = 1;
      chk($sformatf("bp_valid%0d", c), {31'd0, out_valid_o}, 1);
      chk($sformatf("bp_data%0d", c), out_data_o, 9);
      @(posedge clk) #1;
    end
    start_i = 0;
    chk("bp_hold_data", out_data_o, 9);
    out_ready_i = 1;
    @(posedge clk) #1;
    chk("bp_release_valid", {31'd0, out_valid_o}, 0);
    chk("bp_release_busy", {31'd0, busy_o}, 0);
    for (int k = 0; k < 256; k++) data[k] = k;
    run(0, 255, 2, res, lat);
    chk("maxlen_max", res, 254);
    @(posedge clk) #1;
    run(1, 255, 2, res, lat);
    chk("maxlen_min", res, 0);
    @(posedge clk) #1;
    chk("maxlen_idle", {31'd0, busy_o}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
